key_hold_decoder: RTL and testbench
===================================

# key_hold_decoder

Receives a single active-low push-button, debounces it, and measures how long it is held in whole seconds. The result is reported as a one-cycle-valid duration code on release, rounded to the nearest second and saturating at MAX_SEC. The block is the input-side decoder for the team's seconds-based LED sequences: a user reproduces an LED's on-time of 1–4 s by holding the key for that long. It sits between the board key pin and the control logic that consumes the duration code.

## Interface
- TICK_CYC, 50_000_000, clk cycles per second; must be even
- DEB_CYC, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
- MAX_SEC, 4, largest reported duration code; 1..6
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- key_in  input  1  raw key pin; asynchronous to clk, 0 = pressed, may bounce
- holding  output  1  high while a debounced press is in progress
- hold_sec  output  3  live rounded-second count during a press; 0 when idle
- dur_vld  output  1  one-cycle pulse on debounced release
- dur_code  output  3  rounded held seconds, 0..MAX_SEC; valid with dur_vld and held until the next dur_vld
- dur_ovf  output  1  set with dur_vld when the rounded hold exceeds MAX_SEC; held like dur_code

## Operation
- Synchronizer: two flops on key_in, both reset to 1. The second flop output is key_s.
- Debounce: key_db resets to 1, deb_cnt resets to 0.
  - When key_s == key_db: deb_cnt <= 0.
  - When key_s != key_db and deb_cnt == DEB_CYC-1: key_db <= key_s and deb_cnt <= 0.
  - Otherwise deb_cnt increments.
  - A level must therefore differ for DEB_CYC consecutive cycles to be accepted. Any shorter glitch is discarded and restarts the count.
- FSM, 2 states, reset to IDLE:
  - IDLE: on key_db 1→0 (press), go to HOLD, load cnt0 <= TICK_CYC/2 and sec <= 0.
  - HOLD, key_db still 0: if cnt0 == TICK_CYC-1, then cnt0 <= 0 and sec <= sec+1, saturating at MAX_SEC+1. Otherwise cnt0 <= cnt0+1.
  - HOLD, key_db == 1 (release): no count this cycle. Set dur_vld <= 1, dur_code <= min(sec, MAX_SEC), dur_ovf <= (sec == MAX_SEC+1). Go to IDLE.
  - The half-second preload makes sec the hold time rounded to the nearest second.
- A press that rounds to 0 s still produces dur_vld with dur_code = 0.
- holding = (state == HOLD). hold_sec = min(sec, MAX_SEC) in HOLD, 0 in IDLE.
- cnt0 width is clog2(TICK_CYC); deb_cnt width is clog2(DEB_CYC); sec is 3 bits.

## Timing
- Reset values: holding=0, hold_sec=0, dur_vld=0, dur_code=0, dur_ovf=0. Internally key_db=1, state IDLE, and all counters 0.
- Pin-to-key_db latency: 2 + DEB_CYC cycles, identical for press and release. The debounced low width therefore equals the stable pin low width.
- Press: holding rises 1 cycle after key_db falls.
- Release: dur_vld rises 1 cycle after key_db rises and lasts exactly 1 cycle. holding falls in the same cycle dur_vld rises.
- Count rule: let N be the number of HOLD cycles with key_db = 0, excluding the entry cycle. Then sec = floor((N + TICK_CYC/2) / TICK_CYC), saturated at MAX_SEC+1.
- Back-to-back presses: a new press is accepted only after key_db has been high for DEB_CYC cycles, so dur_vld pulses are at least DEB_CYC+1 cycles apart.
- Reset asserted mid-press: all state clears immediately and no dur_vld is produced. If the key is still held at reset release, the press is detected after 2 + DEB_CYC cycles and timed from that point.
- Key held indefinitely: sec stays at MAX_SEC+1 and cnt0 keeps wrapping harmlessly. Release then reports code MAX_SEC with ovf = 1.

## Test plan
All scenarios use TICK_CYC=100, DEB_CYC=4, MAX_SEC=4.
- Reset with key_in=1 → all outputs 0. With key idle, dur_vld stays 0 for 1000 cycles.
- Bounce: 3-cycle low glitches every 5 cycles, repeated 20 times → holding stays 0 and no dur_vld.
- Clean press of 240 cycles → holding high for 240 cycles; hold_sec steps to 1 and then 2; one dur_vld with code=2, ovf=0. A press of 260 cycles → code=3.
- Short press of 30 cycles → dur_vld with code=0, ovf=0. A press bounced on both edges (2-cycle glitches) followed by a stable 140-cycle low → code=1.
- Long press of 600 cycles → hold_sec saturates at 4; dur_vld with code=4, ovf=1. dur_code and dur_ovf hold these values until the next release.
- rst_n pulsed low at cycle 120 of a press → outputs clear with no dur_vld. The key is still held at reset release, so it is re-detected 6 cycles later and the release reports the remaining time.

Source files
------------

// File: rtl/key_hold_decoder_if.sv
// Key pin in, held-duration report out; the decoder takes the slave side.
interface key_hold_decoder_if;
    logic       key_in;
    logic       holding;
    logic [2:0] hold_sec;
    logic       dur_vld;
    logic [2:0] dur_code;
    logic       dur_ovf;

    modport master (
        output key_in,
        input  holding,
        input  hold_sec,
        input  dur_vld,
        input  dur_code,
        input  dur_ovf
    );

    modport slave (
        input  key_in,
        output holding,
        output hold_sec,
        output dur_vld,
        output dur_code,
        output dur_ovf
    );
endinterface

// File: rtl/key_hold_decoder.sv
// Debounces an active-low key and reports its hold time in rounded seconds on release.
// Latency: pin to debounced level 2+DEB_CYC cycles; dur_vld 1 cycle after debounced release; no backpressure.
module key_hold_decoder #(
    parameter int TICK_CYC = 50_000_000,
    parameter int DEB_CYC  = 1_000_000,
    parameter int MAX_SEC  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    key_hold_decoder_if.slave   bus
);
    localparam int CNT_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    localparam logic [2:0]       SEC_MAX  = 3'(MAX_SEC);
    localparam logic [2:0]       SEC_SAT  = 3'(MAX_SEC + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_CYC / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_db;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt0;
    logic [2:0]       r_sec;
    logic             r_dur_vld;
    logic [2:0]       r_dur_code;
    logic             r_dur_ovf;

    logic             w_key_s;
    logic             w_holding;
    logic [2:0]       w_sec_clip;

    assign w_key_s = r_sync2;

    // Both sync flops reset high so an idle key never looks like a press out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.key_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_db  <= 1'b1;
            r_deb_cnt <= '0;
        end else if (w_key_s == r_key_db) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_key_db  <= w_key_s;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    // Half-second preload turns the truncating second counter into round-to-nearest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt0     <= '0;
            r_sec      <= '0;
            r_dur_vld  <= 1'b0;
            r_dur_code <= '0;
            r_dur_ovf  <= 1'b0;
        end else begin
            r_dur_vld <= 1'b0;
            if (r_state == S_IDLE) begin
                if (!r_key_db) begin
                    r_state <= S_HOLD;
                    r_cnt0  <= CNT_HALF;
                    r_sec   <= '0;
                end
            end else if (r_key_db) begin
                r_state    <= S_IDLE;
                r_dur_vld  <= 1'b1;
                r_dur_code <= w_sec_clip;
                r_dur_ovf  <= (r_sec == SEC_SAT);
            end else if (r_cnt0 == CNT_LAST) begin
                r_cnt0 <= '0;
                if (r_sec != SEC_SAT) begin
                    r_sec <= r_sec + 3'd1;
                end
            end else begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
        end
    end

    assign w_sec_clip = (r_sec > SEC_MAX) ? SEC_MAX : r_sec;
    assign w_holding  = (r_state == S_HOLD);

    assign bus.holding  = w_holding;
    assign bus.hold_sec = w_holding ? w_sec_clip : 3'd0;
    assign bus.dur_vld  = r_dur_vld;
    assign bus.dur_code = r_dur_code;
    assign bus.dur_ovf  = r_dur_ovf;
endmodule

// File: tb/tb_key_hold_decoder.sv
// Scoreboard bench for key_hold_decoder with TICK_CYC=100, DEB_CYC=4, MAX_SEC=4.
module tb_key_hold_decoder;
    localparam int TICK = 100;
    localparam int DEB  = 4;
    localparam int MAXS = 4;

    typedef struct {
        int code;
        int ovf;
        int width;
    } exp_t;

    logic clk;
    logic rst_n;
    key_hold_decoder_if u_if();

    key_hold_decoder #(.TICK_CYC(TICK), .DEB_CYC(DEB), .MAX_SEC(MAXS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_push = 0;
    int   vld_cnt = 0;
    int   hold_cnt = 0;
    int   max_sec = 0;
    int   seen_hold = 0;
    int   prev_vld = 0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected report for a debounced low of 'width' cycles (first cycle is the FSM entry).
    task automatic push_exp(input int width);
        exp_t e;
        int   s;
        s = (width - 1 + TICK / 2) / TICK;
        if (s > MAXS + 1) s = MAXS + 1;
        e.code  = (s > MAXS) ? MAXS : s;
        e.ovf   = (s == MAXS + 1) ? 1 : 0;
        e.width = width;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic drive_key(input logic lvl, input int cyc);
        u_if.key_in = lvl;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic press(input int low_cyc);
        push_exp(low_cyc);
        drive_key(1'b0, low_cyc);
        drive_key(1'b1, 30);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            hold_cnt = 0;
            max_sec  = 0;
            prev_vld = 0;
        end else begin
            if (u_if.holding) begin
                hold_cnt++;
                seen_hold = 1;
                if (int'(u_if.hold_sec) > max_sec) max_sec = int'(u_if.hold_sec);
            end
            if (u_if.dur_vld) begin
                vld_cnt++;
                chk_eq("vld_one_cycle", prev_vld, 0);
                chk_eq("holding_low_at_vld", int'(u_if.holding), 0);
                chk_eq("sb_has_entry", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_eq("dur_code", int'(u_if.dur_code), e.code);
                    chk_eq("dur_ovf", int'(u_if.dur_ovf), e.ovf);
                    chk_eq("holding_width", hold_cnt, e.width);
                    chk_eq("hold_sec_peak", max_sec, e.code);
                end
                hold_cnt = 0;
                max_sec  = 0;
            end
            prev_vld = int'(u_if.dur_vld);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d reports, expected %0d", vld_cnt, n_push);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        u_if.key_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_eq("rst_holding", int'(u_if.holding), 0);
        chk_eq("rst_hold_sec", int'(u_if.hold_sec), 0);
        chk_eq("rst_dur_vld", int'(u_if.dur_vld), 0);
        chk_eq("rst_dur_code", int'(u_if.dur_code), 0);
        chk_eq("rst_dur_ovf", int'(u_if.dur_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        drive_key(1'b1, 1000);
        chk_eq("idle_no_vld", vld_cnt, 0);
        chk_eq("idle_no_holding", seen_hold, 0);

        for (int i = 0; i < 20; i++) begin
            drive_key(1'b0, 3);
            drive_key(1'b1, 2);
        end
        drive_key(1'b1, 20);
        chk_eq("bounce_no_holding", seen_hold, 0);
        chk_eq("bounce_no_vld", vld_cnt, 0);

        press(240);
        chk_eq("code_after_240", int'(u_if.dur_code), 2);
        press(260);
        chk_eq("code_after_260", int'(u_if.dur_code), 3);

        press(600);
        chk_eq("long_code", int'(u_if.dur_code), MAXS);
        chk_eq("long_ovf", int'(u_if.dur_ovf), 1);
        drive_key(1'b1, 50);
        chk_eq("long_code_held", int'(u_if.dur_code), MAXS);
        chk_eq("long_ovf_held", int'(u_if.dur_ovf), 1);

        // Reset mid-press: the earlier report must vanish and the press restarts at reset release.
        drive_key(1'b0, 120);
        chk_eq("pre_rst_holding", int'(u_if.holding), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_holding", int'(u_if.holding), 0);
        chk_eq("midrst_hold_sec", int'(u_if.hold_sec), 0);
        chk_eq("midrst_dur_code", int'(u_if.dur_code), 0);
        chk_eq("midrst_dur_ovf", int'(u_if.dur_ovf), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_exp(200);
        drive_key(1'b0, 200);
        drive_key(1'b1, 30);

        press(30);
        chk_eq("short_code", int'(u_if.dur_code), 0);

        // Both edges bounced with 2-cycle glitches; the trailing glitch stays inside the press.
        push_exp(144);
        drive_key(1'b0, 2);
        drive_key(1'b1, 2);
        drive_key(1'b0, 2);
        drive_key(1'b1, 2);
        drive_key(1'b0, 140);
        drive_key(1'b1, 2);
        drive_key(1'b0, 2);
        drive_key(1'b1, 30);
        chk_eq("bounced_code", int'(u_if.dur_code), 1);

        chk_eq("vld_total", vld_cnt, n_push);
        chk_eq("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
